// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush and bubble insertion; 1-cycle latency.
// SKID=1 adds a skid entry so in_ready is registered; SKID=0 gives a single entry with combinational in_ready.
module pipe_stage_reg #(
    parameter int          CTRL_W = 16,
    parameter int          DATA_W = 101,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    logic in_xfer;
    logic out_pop;

    always_comb begin
        if (SKID != 0) begin
            in_ready = !s_valid_q && !flush;
        end else begin
            in_ready = (!m_valid_q || out_ready) && !flush;
        end
    end

    assign in_xfer = in_valid && in_ready;
    assign out_pop = m_valid_q && out_ready;

    // Control is zeroed whenever an entry goes empty so an invalid slot always reads as a NOP.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (SKID != 0) begin
            if (!m_valid_q || (out_pop && !s_valid_q)) begin
                if (in_xfer) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = in_ctrl;
                    m_data_d  = in_data;
                end else begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                end
            end else if (out_pop && s_valid_q) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_ctrl_d  = '0;
                if (in_xfer) begin
                    s_valid_d = 1'b1;
                    s_ctrl_d  = in_ctrl;
                    s_data_d  = in_data;
                end
            end else if (in_xfer) begin
                s_valid_d = 1'b1;
                s_ctrl_d  = in_ctrl;
                s_data_d  = in_data;
            end
        end else begin
            if (in_xfer) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else if (out_pop) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-register instance.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst_n;

    logic         in_valid, in_ready, out_valid, out_ready, flush;
    logic [15:0]  in_ctrl, out_ctrl;
    logic [100:0] in_data, out_data;
    logic [1:0]   occupancy;

    logic         in_valid0, in_ready0, out_valid0, out_ready0, flush0;
    logic [15:0]  in_ctrl0, out_ctrl0;
    logic [100:0] in_data0, out_data0;
    logic [1:0]   occupancy0;

    int checks;
    int failures;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(101), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .occupancy(occupancy)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(101), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .flush(flush0), .occupancy(occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backpressure scenario, one entry per cycle: inputs then expected state at the start of that cycle.
    localparam int BP_IV   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    localparam int BP_ID   [9] = '{'h0A, 'h0B, 'h0C, 'h0C, 'h0C, 'h0C, 'h0D, 0, 0};
    localparam int BP_ORDY [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    localparam int BP_EOV  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    localparam int BP_EOD  [9] = '{0, 'h0A, 'h0A, 'h0A, 'h0A, 'h0B, 'h0C, 'h0D, 'h0D};
    localparam int BP_EIR  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    localparam int BP_EOC  [9] = '{0, 1, 2, 2, 2, 1, 1, 1, 0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0;
        in_valid0 = 0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 0; flush0 = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_ctrl, out_data, occupancy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0d c=%0h d=%0h occ=%0d, want all 0", out_valid, out_ctrl, out_data, occupancy);
        end
        checks++;
        if ({out_valid0, out_ctrl0, out_data0, occupancy0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_noskid: got v=%0d c=%0h d=%0h occ=%0d, want all 0", out_valid0, out_ctrl0, out_data0, occupancy0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, in_ready0} !== 2'b11) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, want 11", {in_ready, in_ready0});
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_ctrl = 16'h00FF; in_data = 101'(i);
            step();
            checks++;
            if ({out_valid, out_ctrl, out_data, occupancy, in_ready} !== {1'b1, 16'h00FF, 101'(i), 2'd1, 1'b1}) begin
                failures++;
                $display("FAIL stream_%0d: got v=%0d c=%0h d=%0h occ=%0d rdy=%0d, want v=1 c=ff d=%0h occ=1 rdy=1",
                         i, out_valid, out_ctrl, out_data, occupancy, in_ready, i);
            end
        end
        in_valid = 0;
        step();
        checks++;
        if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 16'h0, 101'd8, 2'd0}) begin
            failures++;
            $display("FAIL stream_drain: got v=%0d c=%0h d=%0h occ=%0d, want v=0 c=0 d=8 occ=0", out_valid, out_ctrl, out_data, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [120:0] got, want;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            in_valid  = (BP_IV[k] != 0);
            in_ctrl   = 16'h0001;
            in_data   = 101'(BP_ID[k]);
            out_ready = (BP_ORDY[k] != 0);
            #1;
            got  = {out_valid, out_ctrl, out_data, in_ready, occupancy};
            want = {BP_EOV[k] != 0, (BP_EOV[k] != 0) ? 16'h0001 : 16'h0000, 101'(BP_EOD[k]),
                    BP_EIR[k] != 0, 2'(BP_EOC[k])};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL backpressure_cycle%0d: got {v,c,d,rdy,occ}=%0h, want %0h", k, got, want);
            end
            step();
        end
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid = 1; in_ctrl = 16'h0003; in_data = 101'h0A; out_ready = 0;
        step();
        in_data = 101'h0B;
        step();
        in_data = 101'h0E; flush = 1;
        #1;
        checks++;
        if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 101'h0A}) begin
            failures++;
            $display("FAIL flush_setup: got occ=%0d rdy=%0d d=%0h, want occ=2 rdy=0 d=a", occupancy, in_ready, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_ctrl, occupancy, in_ready, out_data} !== {1'b0, 16'h0, 2'd0, 1'b0, 101'h0A}) begin
            failures++;
            $display("FAIL flush_held: got v=%0d c=%0h occ=%0d rdy=%0d d=%0h, want v=0 c=0 occ=0 rdy=0 d=a",
                     out_valid, out_ctrl, occupancy, in_ready, out_data);
        end
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        #1;
        checks++;
        if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL flush_after: got v=%0d c=%0h occ=%0d rdy=%0d, want v=0 c=0 occ=0 rdy=1", out_valid, out_ctrl, occupancy, in_ready);
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b0, 101'h0A}) begin
            failures++;
            $display("FAIL flush_e_dropped: got v=%0d d=%0h, want v=0 d=a", out_valid, out_data);
        end
    endtask

    task automatic test_bubble();
        apply_reset();
        in_valid = 1; in_ctrl = 16'hA5A5; in_data = 101'h1_2345_6789; out_ready = 1;
        step();
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b1, 16'hA5A5, 101'h1_2345_6789}) begin
            failures++;
            $display("FAIL bubble_x: got v=%0d c=%0h d=%0h, want v=1 c=a5a5 d=123456789", out_valid, out_ctrl, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 16'h0, 101'h1_2345_6789, 2'd0}) begin
            failures++;
            $display("FAIL bubble_nop: got v=%0d c=%0h d=%0h occ=%0d, want v=0 c=0 d=123456789 occ=0", out_valid, out_ctrl, out_data, occupancy);
        end
    endtask

    task automatic test_noskid();
        apply_reset();
        in_valid0 = 1; in_ctrl0 = 16'h0011; in_data0 = 101'h11; out_ready0 = 0;
        step();
        in_data0 = 101'h22;
        #1;
        checks++;
        if ({in_ready0, out_valid0, out_data0, occupancy0} !== {1'b0, 1'b1, 101'h11, 2'd1}) begin
            failures++;
            $display("FAIL noskid_stall: got rdy=%0d v=%0d d=%0h occ=%0d, want rdy=0 v=1 d=11 occ=1", in_ready0, out_valid0, out_data0, occupancy0);
        end
        out_ready0 = 1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL noskid_comb_ready: got %0d, want 1", in_ready0);
        end
        flush0 = 1;
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL noskid_flush_ready: got %0d, want 0", in_ready0);
        end
        flush0 = 0;
        step();
        checks++;
        if ({out_valid0, out_data0, occupancy0} !== {1'b1, 101'h22, 2'd1}) begin
            failures++;
            $display("FAIL noskid_swap: got v=%0d d=%0h occ=%0d, want v=1 d=22 occ=1", out_valid0, out_data0, occupancy0);
        end
        for (int i = 1; i <= 4; i++) begin
            in_data0 = 101'(i + 'h30);
            #1;
            checks++;
            if (in_ready0 !== 1'b1) begin
                failures++;
                $display("FAIL noskid_stream_rdy_%0d: got %0d, want 1", i, in_ready0);
            end
            step();
            checks++;
            if ({out_valid0, out_data0} !== {1'b1, 101'(i + 'h30)}) begin
                failures++;
                $display("FAIL noskid_stream_%0d: got v=%0d d=%0h, want v=1 d=%0h", i, out_valid0, out_data0, i + 'h30);
            end
        end
        in_valid0 = 0;
        step();
        checks++;
        if ({out_valid0, out_ctrl0, occupancy0} !== {1'b0, 16'h0, 2'd0}) begin
            failures++;
            $display("FAIL noskid_drain: got v=%0d c=%0h occ=%0d, want v=0 c=0 occ=0", out_valid0, out_ctrl0, occupancy0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid = 1; in_ctrl = 16'h0007; in_data = 101'h0A; out_ready = 0;
        step();
        in_data = 101'h0B;
        step();
        in_valid = 0;
        #1;
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL areset_setup: got occ=%0d, want 2", occupancy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, occupancy} !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got v=%0d c=%0h d=%0h occ=%0d, want all 0", out_valid, out_ctrl, out_data, occupancy);
        end
        step();
        rst_n = 1'b1;
        in_valid = 1; in_ctrl = 16'h0042; in_data = 101'h77; out_ready = 1;
        step();
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b1, 16'h0042, 101'h77, 2'd1}) begin
            failures++;
            $display("FAIL areset_recover: got v=%0d c=%0h d=%0h occ=%0d, want v=1 c=42 d=77 occ=1", out_valid, out_ctrl, out_data, occupancy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_noskid();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
